// File: rtl/bcd_link_pkg.sv
// -----------------------------------------------------------------------------
// bcd_link_pkg
// Definitions shared by the transmit and receive sides of the 4-byte BCD UART
// link: default bit period, frame constants, FSM state encodings and the
// nibble-to-byte mapping. Both sides import this package so they cannot
// disagree on byte layout.
// -----------------------------------------------------------------------------
package bcd_link_pkg;

  // 100 MHz system clock, 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // 8N1 frame and transaction shape.
  localparam int DATA_BITS     = 8;
  localparam int STOP_BITS     = 1;
  localparam int BYTES_PER_TXN = 4;

  // Transaction FSM encoding (top level).
  localparam logic [1:0] TOP_IDLE  = 2'd0;
  localparam logic [1:0] TOP_SEND  = 2'd1;
  localparam logic [1:0] TOP_DRAIN = 2'd2;

  // Serializer FSM encoding.
  localparam logic [1:0] SER_IDLE  = 2'd0;
  localparam logic [1:0] SER_START = 2'd1;
  localparam logic [1:0] SER_DATA  = 2'd2;
  localparam logic [1:0] SER_STOP  = 2'd3;

  // Byte idx carries nibble idx of both words: high nibble from the
  // high-voltage word, low nibble from the low-voltage word.
  function automatic logic [7:0] pack_byte(input logic [15:0] data12,
                                           input logic [15:0] data16,
                                           input logic [1:0]  idx);
    pack_byte = {data16[{idx, 2'b00} +: 4], data12[{idx, 2'b00} +: 4]};
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// -----------------------------------------------------------------------------
// uart_tx_8n1
// UART 8N1 serializer with a valid/ready byte handshake. A byte is accepted in
// a cycle where byte_valid and byte_ready are both high; the start bit appears
// on tx from the following cycle. Every bit lasts CLKS_PER_BIT cycles, data is
// sent LSB first, and byte_ready returns high the cycle after the stop bit.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset; abandons any frame in flight
//   byte_valid - upstream has a byte on byte_data
//   byte_data  - byte to transmit
//   byte_ready - serializer idle and able to accept a byte
//   tx         - registered serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx_8n1
  import bcd_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end    = (cnt_q == CNT_LAST);
  assign byte_ready = (state_q == SER_IDLE);
  assign tx         = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      SER_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        tx_d  = 1'b1;
        if (byte_valid) begin
          state_d = SER_START;
          shift_d = byte_data;
          tx_d    = 1'b0;
        end
      end
      SER_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SER_DATA;
          // The shift register always presents the next data bit in bit 0.
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SER_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = SER_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SER_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = SER_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SER_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/bcd16_pack_tx.sv
// -----------------------------------------------------------------------------
// bcd16_pack_tx
// Sends two 16-bit BCD words as four UART 8N1 frames. Byte k holds nibble k of
// data16 (high) and data12 (low); bytes go out k = 0..3. The words are latched
// when start is accepted in IDLE; start while busy is dropped.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request to send, only looked at while idle
//   data12 - low-voltage BCD word
//   data16 - high-voltage BCD word
//   busy   - registered, high while a transaction is in progress
//   done   - registered one-cycle pulse after the last stop bit
//   tx     - registered serial line, idle high
// -----------------------------------------------------------------------------
module bcd16_pack_tx
  import bcd_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data12,
  input  logic [15:0] data16,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_TXN - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] d12_q, d12_d;
  logic [15:0] d16_q, d16_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;

  assign byte_valid = (state_q == TOP_SEND);
  assign byte_data  = pack_byte(d12_q, d16_q, idx_q);
  assign busy       = busy_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d12_d   = d12_q;
    d16_d   = d16_q;
    done_d  = 1'b0;
    case (state_q)
      TOP_IDLE: begin
        if (start) begin
          d12_d   = data12;
          d16_d   = data16;
          idx_d   = '0;
          state_d = TOP_SEND;
        end
      end
      TOP_SEND: begin
        // byte_valid is implied in this state, so ready alone is the handshake.
        if (byte_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = TOP_DRAIN;
          end
        end
      end
      TOP_DRAIN: begin
        // The serializer only reports ready again once the last stop bit ends.
        if (byte_ready) begin
          state_d = TOP_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = TOP_IDLE;
      end
    endcase
    // Registered from the next state so busy and done switch on the same edge.
    busy_d = (state_d != TOP_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TOP_IDLE;
      idx_q   <= '0;
      d12_q   <= '0;
      d16_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d12_q   <= d12_d;
      d16_q   <= d16_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx        (tx)
  );

endmodule

// File: tb/tb_bcd16_pack_tx.sv
// -----------------------------------------------------------------------------
// tb_bcd16_pack_tx
// Drives bcd16_pack_tx with N = 4 cycles per bit. Each case records tx, busy and
// done for a fixed window and compares them with waveforms built from the
// link rules: a transaction accepted at cycle t owns cycles t+1..t+165 (busy),
// pulses done at t+166 and puts frame k's start bit at t+2+41k.
// -----------------------------------------------------------------------------
module tb_bcd16_pack_tx;

  localparam int N   = 4;
  localparam int W   = 340;           // cycles recorded per case
  localparam int TXN = 6 + 40 * N;    // accept-to-done distance
  localparam int FRM = 10 * N + 1;    // frame period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data12 = '0;
  logic [15:0] data16 = '0;
  logic        busy, done, tx;

  bcd16_pack_tx #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data12(data12),
    .data16(data16),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus, capture and expectation for one case.
  logic        st_v[W];
  logic [15:0] a12[W];
  logic [15:0] a16[W];
  logic        cap_tx[W], cap_busy[W], cap_done[W];
  logic        exp_tx[W], exp_busy[W], exp_done[W];
  int          acc_cnt;
  int          acc_t[4];

  typedef struct packed {
    logic [15:0] d12;
    logic [15:0] d16;
    logic [31:0] bytes;   // byte k at [8k +: 8]
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  // Byte k of a transaction, from plain nibble arithmetic.
  function automatic int ref_byte(input logic [15:0] w12, input logic [15:0] w16, input int k);
    int lo, hi;
    lo = (int'(w12) / (16 ** k)) % 16;
    hi = (int'(w16) / (16 ** k)) % 16;
    return hi * 16 + lo;
  endfunction

  // Read byte k of the transaction accepted at t off the captured line,
  // sampling each data bit in the middle of its period.
  function automatic int dec_byte(input int t, input int k);
    int v = 0;
    for (int i = 0; i < 8; i++) begin
      if (cap_tx[t + 2 + k * FRM + N * (1 + i) + N / 2]) v += (1 << i);
    end
    return v;
  endfunction

  task automatic build_model();
    int next_free = 0;
    acc_cnt = 0;
    for (int c = 0; c < W; c++) begin
      exp_tx[c]   = 1'b1;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    for (int c = 0; c < W; c++) begin
      if (st_v[c] && c >= next_free) begin
        if (acc_cnt < 4) acc_t[acc_cnt] = c;
        acc_cnt++;
        next_free = c + TXN;
        for (int b = c + 1; b < c + TXN && b < W; b++) exp_busy[b] = 1'b1;
        if (c + TXN < W) exp_done[c + TXN] = 1'b1;
        for (int k = 0; k < 4; k++) begin
          int by = ref_byte(a12[c], a16[c], k);
          int s  = c + 2 + k * FRM;
          for (int j = 0; j < 10; j++) begin
            logic bv;
            if (j == 0)      bv = 1'b0;
            else if (j == 9) bv = 1'b1;
            else             bv = 1'((by >> (j - 1)) & 1);
            for (int q = 0; q < N; q++) begin
              if (s + j * N + q < W) exp_tx[s + j * N + q] = bv;
            end
          end
        end
      end
    end
  endtask

  function automatic int first_diff(input logic a[W], input logic b[W]);
    for (int c = 0; c < W; c++) if (a[c] !== b[c]) return c;
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle 0 is the first recorded cycle; start is driven for it at that negedge.
  task automatic run_case(input string nm, input logic [15:0] d12, input logic [15:0] d16,
                          input bit hold, input int pa, input int pb,
                          input bit rnd_after, input bit do_rst);
    int d;
    if (do_rst) apply_reset();
    for (int c = 0; c < W; c++) begin
      st_v[c] = hold || (c == 0) || (c == pa) || (c == pb);
      a12[c]  = (c == 0 || !rnd_after) ? d12 : 16'($urandom);
      a16[c]  = (c == 0 || !rnd_after) ? d16 : 16'($urandom);
    end
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      cap_tx[c]   = tx;
      cap_busy[c] = busy;
      cap_done[c] = done;
      start  = st_v[c];
      data12 = a12[c];
      data16 = a16[c];
    end
    @(negedge clk);
    start = 1'b0;
    build_model();

    total++;
    d = first_diff(cap_tx, exp_tx);
    if (d >= 0) begin
      bad++;
      $display("FAIL %s tx_wave: cycle %0d got %0b want %0b", nm, d, cap_tx[d], exp_tx[d]);
    end
    total++;
    d = first_diff(cap_busy, exp_busy);
    if (d >= 0) begin
      bad++;
      $display("FAIL %s busy_wave: cycle %0d got %0b want %0b", nm, d, cap_busy[d], exp_busy[d]);
    end
    total++;
    d = first_diff(cap_done, exp_done);
    if (d >= 0) begin
      bad++;
      $display("FAIL %s done_wave: cycle %0d got %0b want %0b", nm, d, cap_done[d], exp_done[d]);
    end

    for (int i = 0; i < acc_cnt && i < 4; i++) begin
      if (acc_t[i] + TXN <= W) begin
        $display("txn %s t=%0d data12=%h data16=%h bytes=%02h %02h %02h %02h",
                 nm, acc_t[i], a12[acc_t[i]], a16[acc_t[i]],
                 dec_byte(acc_t[i], 0), dec_byte(acc_t[i], 1),
                 dec_byte(acc_t[i], 2), dec_byte(acc_t[i], 3));
      end
    end
  endtask

  initial begin
    int n;
    int first;

    tbl[0] = '{d12: 16'h4321, d16: 16'h8765, bytes: 32'h84736251};
    tbl[1] = '{d12: 16'h0000, d16: 16'h0000, bytes: 32'h00000000};
    tbl[2] = '{d12: 16'hFFFF, d16: 16'h1234, bytes: 32'h1F2F3F4F};
    tbl[3] = '{d12: 16'hA5C3, d16: 16'h5A3C, bytes: 32'h5AA53CC3};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;

    // Table vectors; input words are randomised after the accept cycle,
    // so every entry also checks that the words were latched at cycle 0.
    for (int i = 0; i < 4; i++) begin
      run_case($sformatf("tbl%0d", i), tbl[i].d12, tbl[i].d16, 1'b0, -1, -1, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("tbl%0d_byte%0d", i, k), dec_byte(0, k), int'(tbl[i].bytes[8 * k +: 8]));
      end
      if (i == 0) begin
        first = -1;
        n = 0;
        for (int c = 0; c < W; c++) begin
          if (cap_done[c] && first < 0) first = c;
          if (cap_busy[c]) n++;
        end
        chk("basic_done_cycle", first, 166);
        chk("basic_busy_cycles", n, 165);
      end
      if (i == 1) begin
        for (int k = 0; k < 4; k++) begin
          int s = 2 + k * FRM;
          n = 0;
          while (s + n < W && cap_tx[s + n] == 1'b0) n++;
          chk($sformatf("bit_timing_low_run_frame%0d", k), n, 36);
          chk($sformatf("bit_timing_high_before_frame%0d", k), int'(cap_tx[s - 1]), 1);
        end
      end
    end

    // Start pulses while busy are dropped.
    run_case("ignored", 16'h1357, 16'h2468, 1'b0, 10, 100, 1'b1, 1'b1);
    n = 0;
    for (int c = 0; c < W; c++) if (cap_done[c]) n++;
    chk("ignored_done_count", n, 1);
    chk("ignored_byte0", dec_byte(0, 0), 8'h87);

    // Start held high: a new transaction every 166 cycles.
    run_case("b2b", 16'h9999, 16'h0000, 1'b1, -1, -1, 1'b0, 1'b1);
    chk("b2b_idle_167", int'(cap_tx[167]), 1);
    chk("b2b_start_168", int'(cap_tx[168]), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_second_byte%0d", k), dec_byte(166, k), 8'h09);
    end

    // Reset in the middle of frame 1 (a data bit that is 0).
    apply_reset();
    @(negedge clk);
    start = 1'b1;
    data12 = 16'h0000;
    data16 = 16'h0000;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrst_tx_before", int'(tx), 0);
    chk("midrst_busy_before", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", int'(tx), 1);
    chk("midrst_busy_async", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      int n_tx0 = 0, n_busy = 0, n_done = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (!tx) n_tx0++;
        if (busy) n_busy++;
        if (done) n_done++;
      end
      chk("midrst_tx_low_after", n_tx0, 0);
      chk("midrst_busy_after", n_busy, 0);
      chk("midrst_done_after", n_done, 0);
    end
    run_case("after_rst", 16'h4321, 16'h8765, 1'b0, -1, -1, 1'b1, 1'b0);
    chk("after_rst_byte0", dec_byte(0, 0), 8'h51);
    chk("after_rst_byte3", dec_byte(0, 3), 8'h84);

    // Random words and a random extra start pulse, checked against the model.
    for (int r = 0; r < 6; r++) begin
      run_case($sformatf("rnd%0d", r), 16'($urandom), 16'($urandom), 1'b0,
               int'($urandom_range(1, W - 1)), -1, 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd16_pack_tx.md
# bcd16_pack_tx

Transmit-side counterpart of the 4-byte BCD UART link. It accepts two 16-bit BCD words (low-voltage `data12`, high-voltage `data16`) and emits them on a serial line as 4 UART 8N1 frames. Each byte carries one nibble of each word: low nibble from `data12`, high nibble from `data16`, least significant nibble first. It sits between the measurement/BCD conversion logic and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 868, clock cycles per UART bit (100 MHz / 115200); legal minimum 2.
- `clk` input 1: single system clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request to send; sampled only in IDLE.
- `data12` input 16: low-voltage BCD word, latched on the accepted `start`.
- `data16` input 16: high-voltage BCD word, latched on the accepted `start`.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle pulse at the end of the transaction.
- `tx` output 1: serial line, idle high.

## Operation
- Byte k (k = 0..3) = {`data16`[4k+3:4k], `data12`[4k+3:4k]}. Bytes are sent in order k = 0, 1, 2, 3.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Every bit lasts CLKS_PER_BIT cycles.
- Top FSM states:
  - IDLE: on `start`=1, latch both words, clear byte index, go to SEND.
  - SEND: hold `byte_valid` high with byte[idx]. On each handshake (`byte_valid` & `byte_ready`), increment idx. The handshake for idx 3 moves to DRAIN.
  - DRAIN: wait for `byte_ready`=1 (last stop bit finished), then return to IDLE and pulse `done`.
- Serializer FSM states: IDLE (`byte_ready`=1, `tx`=1), START, DATA (bit counter 0..7), STOP. It returns to IDLE after the stop bit.
- The bit-period counter is ceil(log2(CLKS_PER_BIT)) bits wide and wraps to 0 at CLKS_PER_BIT-1. The bit counter is 3 bits wide; the byte index is 2 bits wide.
- `start` while busy: ignored, with no queuing. Input word changes after the accept cycle have no effect.
- Reset (at any time, including mid-frame): `tx`=1, `busy`=0, `done`=0, both FSMs in IDLE, all counters and latched words 0. Any partial frame is abandoned.
- BCD validity of nibbles is not checked; nibbles are transmitted verbatim.

## Timing
- Let N = CLKS_PER_BIT. Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- `busy` is high from cycle 1 through cycle 5+40N inclusive.
- Frame k's start bit (`tx`=0) begins at cycle 2 + k·(10N+1). The frame period is 10N+1, so exactly 1 extra idle-high cycle separates consecutive frames.
- The last stop bit ends at cycle 4+40N. The serializer is back in IDLE at cycle 5+40N.
- `done`=1 only in cycle 6+40N, with `busy`=0 in that same cycle. A `start` sampled in cycle 6+40N is accepted.
- `busy`, `done` and `tx` are registered outputs (no combinational path from inputs).

## Structure
- Shared package `bcd_link_pkg` holds: the default CLKS_PER_BIT, the frame constants (8 data bits, 1 stop bit, bytes per transaction = 4), and the nibble-to-byte mapping function, so receive and transmit sides share one definition.
- One sub-module: `uart_tx_8n1` (serializer with `byte_valid`/`byte_ready` handshake, `tx` output). The top holds the latch, byte index and transaction FSM.

## Test plan
All cases run with N = 4, so `done` falls at cycle 166.
- Basic send: `data12`=16'h4321, `data16`=16'h8765, pulse `start` → decoded bytes 0x51, 0x62, 0x73, 0x84 in that order; `done` at cycle 166; `busy` high for cycles 1–165.
- Bit timing: `data12`=16'h0000, `data16`=16'h0000 → each frame has `tx`=0 for 36 cycles then 1 for 5 cycles; frame starts at cycles 2, 43, 84, 125.
- Ignored start: pulse `start` at cycles 10 and 100 with different data → only the first words are sent; no second transaction; exactly one `done`.
- Back-to-back: hold `start`=1 continuously with 16'h9999/16'h0000 → 0x09 ×4 repeated; second transaction's first start bit at cycle 168.
- Reset mid-operation: deassert `rst_n` at cycle 50 for 3 cycles → `tx`=1, `busy`=0 immediately (asynchronous); no `done`; a new `start` after release sends cleanly from byte 0.
- Latch check: change `data12`/`data16` at cycle 1 → transmitted bytes match the values present at cycle 0.
